// File: rtl/sensor_conditioner.sv
// sensor_conditioner: moving-average front end for the relay-protection FSM.
// Keeps the last 2^LOG2_WIN raw ADC samples in a circular buffer with a running
// sum, qualifies the filtered reading with sen_enable once the window is full,
// and drops to STALE when the sample feed stops for TIMEOUT_TICKS ticks.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_FILL  | window partially populated, sen is a partial average
//   ST_RUN   | window full, sen valid, sen_enable high
//   ST_STALE | feed stalled, sen frozen, next sample restarts the window
module sensor_conditioner #(
    parameter int LOG2_WIN      = 3,
    parameter int TIMEOUT_TICKS = 63,
    parameter int RAW_W         = 12
) (
    input  logic                clk_16ms,
    input  logic                rst,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic [RAW_W-1:0]    sample_data,
    output logic [15:0]         sen,
    output logic                sen_enable,
    output logic                stale,
    output logic [LOG2_WIN:0]   fill_cnt
);
    localparam int WIN    = 1 << LOG2_WIN;
    localparam int SUM_W  = RAW_W + LOG2_WIN;
    localparam int IDLE_W = 8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [RAW_W-1:0]    win_buf [WIN];
    logic [SUM_W-1:0]    sum;
    logic [LOG2_WIN-1:0] wp;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_nxt;

    logic                accept;
    logic                idle_hit;
    logic                fill_last;
    logic [SUM_W-1:0]    sum_slide;

    assign accept    = sample_valid & ~clear;
    // Old entry is subtracted even while filling; it is zero there because the buffer is flushed.
    assign sum_slide = sum + SUM_W'(sample_data) - SUM_W'(win_buf[wp]);
    assign fill_last = (fill_cnt == (LOG2_WIN+1)'(WIN - 1));

    // Saturating idle counter: cleared by any strobe, otherwise counts toward the timeout.
    always_comb begin
        idle_nxt = idle_cnt;
        if (sample_valid) begin
            idle_nxt = '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT_TICKS)) begin
            idle_nxt = idle_cnt + 1'b1;
        end
    end

    assign idle_hit = (idle_nxt == IDLE_W'(TIMEOUT_TICKS));

    // State register.
    always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides everything, a full-window accept beats the timeout.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_FILL;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept && fill_last) begin
                        state_nxt = ST_RUN;
                    end else if (idle_hit) begin
                        state_nxt = ST_STALE;
                    end
                end
                ST_RUN: begin
                    if (idle_hit) begin
                        state_nxt = ST_STALE;
                    end
                end
                ST_STALE: begin
                    if (accept) begin
                        state_nxt = ST_FILL;
                    end
                end
                default: state_nxt = ST_FILL;
            endcase
        end
    end

    // Qualifier outputs decoded straight from the state, so they are mutually exclusive.
    always_comb begin
        sen_enable = 1'b0;
        stale      = 1'b0;
        case (state)
            ST_RUN:   sen_enable = 1'b1;
            ST_STALE: stale      = 1'b1;
            default: begin
                sen_enable = 1'b0;
                stale      = 1'b0;
            end
        endcase
    end

    // Window buffer, running sum, pointer, fill count and registered filtered reading.
    always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) begin
                win_buf[i] <= '0;
            end
            sum      <= '0;
            wp       <= '0;
            idle_cnt <= '0;
            fill_cnt <= '0;
            sen      <= '0;
        end else if (clear) begin
            for (int i = 0; i < WIN; i++) begin
                win_buf[i] <= '0;
            end
            sum      <= '0;
            wp       <= '0;
            idle_cnt <= '0;
            fill_cnt <= '0;
            sen      <= '0;
        end else begin
            idle_cnt <= idle_nxt;
            if (accept) begin
                if (state == ST_STALE) begin
                    // Restart: stale history is discarded, this sample becomes entry 0.
                    for (int i = 1; i < WIN; i++) begin
                        win_buf[i] <= '0;
                    end
                    win_buf[0] <= sample_data;
                    sum        <= SUM_W'(sample_data);
                    wp         <= LOG2_WIN'(1);
                    fill_cnt   <= (LOG2_WIN+1)'(1);
                    sen        <= 16'(sample_data >> LOG2_WIN);
                end else begin
                    win_buf[wp] <= sample_data;
                    sum         <= sum_slide;
                    wp          <= wp + 1'b1;
                    if (state == ST_FILL) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                    sen         <= 16'(sum_slide >> LOG2_WIN);
                end
            end
        end
    end

endmodule
